mm_bram_tiled_acc_dpath: RTL and testbench
==========================================

Name: mm_bram_tiled_acc_dpath

Overview:
Parallel row-times-matrix datapath for rows longer than one SRAM word. It accepts a reduction dimension of up to LENGTH*K_TILES_MAX elements, one LENGTH-wide slice (tile) per beat, and holds a wide per-column partial sum across tiles. After the last tile it shifts, saturates and emits one DATA_WIDTH-per-column result row with its write address, using a ready/valid handshake toward the result-SRAM writer. It sits between the source-SRAM reader/controller and the result-SRAM.

Parameters:
- DATA_WIDTH, 8, signed operand and output element width
- LENGTH, 4, elements per tile (power of 2, ≥2)
- COL_NUM, 4, output columns (parallel dot-product lanes)
- ROW_NUM, 32, result rows; ROW_ADDR_WIDTH = $clog2(ROW_NUM)
- K_TILES_MAX, 4, maximum tiles per row; KT_WIDTH = $clog2(K_TILES_MAX+1)
- OUT_SHIFT, 0, arithmetic right shift applied before saturation
- derived: TREE_LAT = 1+$clog2(LENGTH); ACC_WIDTH = 2*DATA_WIDTH+$clog2(LENGTH*K_TILES_MAX)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cfg_k_tiles  in  KT_WIDTH  tiles in this row; sampled on the first tile; 0 is treated as 1
- in_valid  in  1  tile beat valid
- in_ready  out  1  block accepts a tile
- row_data_in  in  DATA_WIDTH*LENGTH  tile slice; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- weights  in  DATA_WIDTH*LENGTH*COL_NUM  tile weights; element (k,j) at index k*COL_NUM+j
- row_addr_in  in  ROW_ADDR_WIDTH  result row address; sampled on the first tile
- out_valid  out  1  result row valid
- out_ready  in  1  result writer accepts
- row_data_out  out  DATA_WIDTH*COL_NUM  saturated results; column j at [j*DATA_WIDTH +: DATA_WIDTH]
- row_wraddr  out  ROW_ADDR_WIDTH  address of the result row
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset: state IDLE; tile counter 0; accumulators 0; pipeline valids 0; out_valid 0; row_data_out 0; row_wraddr 0; busy 0; in_ready 1.
- FSM states: IDLE, ACCUM, DRAIN, OUT.
  - IDLE: in_ready=1. A handshake (in_valid&in_ready) latches cfg_k_tiles as ktot and row_addr_in, and marks the beat "first". If ktot==1, go to DRAIN; otherwise go to ACCUM with count=1.
  - ACCUM: in_ready=1. Each handshake increments count. The beat with count==ktot-1 is the last; go to DRAIN. Idle cycles (in_valid=0) are permitted.
  - DRAIN: in_ready=0. Wait until the tagged last beat has left the accumulate stage, then go to OUT.
  - OUT: out_valid=1, data and address stable until out_valid&out_ready, then go to IDLE. in_ready=0 throughout.
- Per lane pipeline:
  - stage 1 registers LENGTH signed products;
  - $clog2(LENGTH) registered adder-tree stages follow;
  - the accumulate stage adds the tree result into acc[j], or loads it when the beat is tagged first.
  - A valid/first/last tag travels with each beat.
- Latency: last tile accepted at edge t → out_valid high after edge t+TREE_LAT+2. With LENGTH=4 this is 5 cycles.
- Output arithmetic:
  - v = acc >>> OUT_SHIFT (arithmetic);
  - clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
  - result registered on entry to OUT.
- All sums are full precision in ACC_WIDTH, so there is no overflow before saturation.
- Boundaries:
  - cfg_k_tiles > K_TILES_MAX is clamped to K_TILES_MAX.
  - cfg_k_tiles is ignored on non-first beats.
  - out_ready held low stalls indefinitely in OUT with no input accepted.
  - out_ready is a don't-care outside OUT.
  - Reset asserted mid-row or mid-OUT aborts the row: state and outputs return to reset values the next cycle, and the partial row is discarded.
- Throughput: one tile per cycle in ACCUM; per-row overhead is TREE_LAT+2 cycles plus the handshake wait.

Optional Feature:
MM_ACC_RELU_EN
- Defined: negative v is forced to 0 before saturation, so outputs lie in [0, 2^(DATA_WIDTH-1)-1].
- Undefined: signed saturation only, as above.

Decomposition:
- Package mm_tiled_pkg holds:
  - the FSM state enum (IDLE/ACCUM/DRAIN/OUT);
  - a saturate/shift function;
  - the localparam formulas for TREE_LAT and ACC_WIDTH.
- One natural sub-module: mm_dot_tree, a pipelined signed LENGTH-element dot product with a sideband tag and fixed latency TREE_LAT. It is instantiated COL_NUM times.

Test Plan:
- Single tile: cfg_k_tiles=1, row=[1,2,3,4], all weights 1, row_addr_in=7 → out_valid after 5 cycles, each column 10, row_wraddr=7.
- Four tiles back-to-back: row all 2, weights all 3 → each column 2*3*16=96. in_ready low from DRAIN until the out handshake.
- Saturation: row all 127, weights all 127, cfg_k_tiles=4 → 127 per column. Repeat with weights all -128 → -128, or 0 with MM_ACC_RELU_EN defined.
- Backpressure and gaps: insert idle cycles between tiles and hold out_ready=0 for 10 cycles → data and address stable, no input accepted, single transfer on release.
- Reset mid-row: assert reset after 2 of 4 tiles → busy=0 and out_valid=0 next cycle. A following 1-tile row gives a clean result with no residue.
- Config edge: cfg_k_tiles=0 → behaves as 1 tile. cfg_k_tiles=7 with K_TILES_MAX=4 → clamped to 4 tiles.

Source files
------------

// File: rtl/mm_tiled_pkg.sv
// Shared types and helpers for the tiled row-times-matrix accumulator datapath.
package mm_tiled_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mm_state_e;

  // Product register plus one register per adder-tree level.
  function automatic int tree_lat_f(input int length);
    return 1 + $clog2(length);
  endfunction

  // Full-precision width for LENGTH*K_TILES_MAX products of two DATA_WIDTH operands.
  function automatic int acc_width_f(input int dw, input int length, input int kt);
    return 2 * dw + $clog2(length * kt);
  endfunction

  // Arithmetic shift, optional clamp of negatives to zero, then signed saturation to dw bits.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] v,
                                                   input int shift,
                                                   input int dw,
                                                   input logic relu);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = v >>> shift;
    if (relu && (s < 64'sd0)) s = 64'sd0;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mm_dot_tree.sv
// Pipelined signed LENGTH-element dot product with a sideband tag; fixed latency TREE_LAT.
module mm_dot_tree
  import mm_tiled_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int TAG_WIDTH  = 2,
  parameter int TREE_LAT   = tree_lat_f(LENGTH),
  parameter int SUM_WIDTH  = 2 * DATA_WIDTH + $clog2(LENGTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  input  logic [DATA_WIDTH*LENGTH-1:0] a,
  input  logic [DATA_WIDTH*LENGTH-1:0] b,
  output logic                         out_valid,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic signed [SUM_WIDTH-1:0]  out_sum
);

  localparam int NODES = 2 * LENGTH - 1;

  // Heap-ordered tree: leaves at LENGTH-1.., node n sums children 2n+1 and 2n+2.
  logic signed [SUM_WIDTH-1:0] node_q [NODES];
  logic [TREE_LAT-1:0]         vld_q;
  logic [TAG_WIDTH-1:0]        tag_q [TREE_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < TREE_LAT; s++) tag_q[s] <= '0;
      for (int n = 0; n < NODES; n++) node_q[n] <= '0;
    end else begin
      vld_q    <= {vld_q[TREE_LAT-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int s = 1; s < TREE_LAT; s++) tag_q[s] <= tag_q[s-1];
      for (int n = 0; n < LENGTH - 1; n++) node_q[n] <= node_q[2*n+1] + node_q[2*n+2];
      for (int i = 0; i < LENGTH; i++)
        node_q[LENGTH-1+i] <= SUM_WIDTH'($signed(a[i*DATA_WIDTH +: DATA_WIDTH]))
                            * SUM_WIDTH'($signed(b[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  assign out_valid = vld_q[TREE_LAT-1];
  assign out_tag   = tag_q[TREE_LAT-1];
  assign out_sum   = node_q[0];

endmodule

// File: rtl/mm_bram_tiled_acc_dpath.sv
// Tiled row-times-matrix accumulator: K tiles per row, wide partial sums, saturated result row.
// Optional build macro MM_ACC_RELU_EN clamps negative results to zero before saturation.
module mm_bram_tiled_acc_dpath
  import mm_tiled_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int LENGTH         = 4,
  parameter int COL_NUM        = 4,
  parameter int ROW_NUM        = 32,
  parameter int K_TILES_MAX    = 4,
  parameter int OUT_SHIFT      = 0,
  parameter int ROW_ADDR_WIDTH = $clog2(ROW_NUM),
  parameter int KT_WIDTH       = $clog2(K_TILES_MAX + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [KT_WIDTH-1:0]                   cfg_k_tiles,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH*LENGTH-1:0]          row_data_in,
  input  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]  weights,
  input  logic [ROW_ADDR_WIDTH-1:0]             row_addr_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH*COL_NUM-1:0]         row_data_out,
  output logic [ROW_ADDR_WIDTH-1:0]             row_wraddr,
  output logic                                  busy,
  output mm_state_e                             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // source holds payload while valid is high and ready low, and never drops valid un-transferred.

  localparam int TREE_LAT  = tree_lat_f(LENGTH);
  localparam int ACC_WIDTH = acc_width_f(DATA_WIDTH, LENGTH, K_TILES_MAX);
  localparam int SUM_WIDTH = 2 * DATA_WIDTH + $clog2(LENGTH);
`ifdef MM_ACC_RELU_EN
  localparam logic RELU_EN = 1'b1;
`else
  localparam logic RELU_EN = 1'b0;
`endif

  mm_state_e                   state_q;
  logic [KT_WIDTH-1:0]         ktot_q;
  logic [KT_WIDTH-1:0]         count_q;
  logic [KT_WIDTH-1:0]         k_eff;
  logic [ROW_ADDR_WIDTH-1:0]   addr_q;
  logic                        accept;
  logic                        first_in;
  logic                        last_in;

  logic [DATA_WIDTH*LENGTH-1:0] wcol  [COL_NUM];
  logic [COL_NUM-1:0]           t_vld;
  logic [1:0]                   t_tag [COL_NUM];
  logic signed [SUM_WIDTH-1:0]  t_sum [COL_NUM];
  logic                         beat_vld;
  logic                         beat_first;
  logic                         beat_last;

  logic signed [ACC_WIDTH-1:0]   acc_q [COL_NUM];
  logic                          acc_last_q;
  logic [DATA_WIDTH*COL_NUM-1:0] sat_d;
  logic [DATA_WIDTH*COL_NUM-1:0] sat_q;
  logic                          sat_vld_q;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;
  assign first_in  = (state_q == IDLE);

  always_comb begin
    k_eff = cfg_k_tiles;
    if (cfg_k_tiles == '0) k_eff = KT_WIDTH'(1);
    else if (cfg_k_tiles > KT_WIDTH'(K_TILES_MAX)) k_eff = KT_WIDTH'(K_TILES_MAX);
  end

  assign last_in = first_in ? (k_eff == KT_WIDTH'(1)) : (count_q == ktot_q - KT_WIDTH'(1));

  always_comb begin
    for (int j = 0; j < COL_NUM; j++) begin
      wcol[j] = '0;
      for (int k = 0; k < LENGTH; k++)
        wcol[j][k*DATA_WIDTH +: DATA_WIDTH] = weights[(k*COL_NUM+j)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar j = 0; j < COL_NUM; j++) begin : g_lane
    mm_dot_tree #(
      .DATA_WIDTH(DATA_WIDTH),
      .LENGTH    (LENGTH),
      .TAG_WIDTH (2),
      .TREE_LAT  (TREE_LAT),
      .SUM_WIDTH (SUM_WIDTH)
    ) u_tree (
      .clk      (clk),
      .reset    (reset),
      .in_valid (accept),
      .in_tag   ({first_in, last_in}),
      .a        (row_data_in),
      .b        (wcol[j]),
      .out_valid(t_vld[j]),
      .out_tag  (t_tag[j]),
      .out_sum  (t_sum[j])
    );
  end

  // All lanes carry identical valid/tag; AND-reduce them into one beat descriptor.
  always_comb begin
    beat_vld   = &t_vld;
    beat_first = 1'b1;
    beat_last  = 1'b1;
    for (int j = 0; j < COL_NUM; j++) begin
      beat_first = beat_first & t_tag[j][1];
      beat_last  = beat_last & t_tag[j][0];
    end
  end

  always_comb begin
    sat_d = '0;
    for (int j = 0; j < COL_NUM; j++)
      sat_d[j*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(shift_sat(64'(acc_q[j]), OUT_SHIFT, DATA_WIDTH, RELU_EN));
  end

  // Accumulate stage followed by a shift/saturate register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < COL_NUM; j++) acc_q[j] <= '0;
      acc_last_q <= 1'b0;
      sat_q      <= '0;
      sat_vld_q  <= 1'b0;
    end else begin
      acc_last_q <= beat_vld && beat_last;
      sat_vld_q  <= acc_last_q;
      sat_q      <= sat_d;
      if (beat_vld) begin
        for (int j = 0; j < COL_NUM; j++)
          acc_q[j] <= beat_first ? ACC_WIDTH'(t_sum[j]) : acc_q[j] + ACC_WIDTH'(t_sum[j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ktot_q       <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      out_valid    <= 1'b0;
      row_data_out <= '0;
      row_wraddr   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          ktot_q  <= k_eff;
          addr_q  <= row_addr_in;
          count_q <= KT_WIDTH'(1);
          state_q <= last_in ? DRAIN : ACCUM;
        end
        ACCUM: if (accept) begin
          count_q <= count_q + KT_WIDTH'(1);
          if (last_in) state_q <= DRAIN;
        end
        DRAIN: if (sat_vld_q) begin
          state_q      <= OUT;
          out_valid    <= 1'b1;
          row_data_out <= sat_q;
          row_wraddr   <= addr_q;
        end
        OUT: if (out_ready) begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_bram_tiled_acc_dpath.sv
// Directed bench for mm_bram_tiled_acc_dpath with hand-computed expected result rows.
module tb_mm_bram_tiled_acc_dpath;
  import mm_tiled_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   cfg_k_tiles;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  row_data_in;
  logic [127:0] weights;
  logic [4:0]   row_addr_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  row_data_out;
  logic [4:0]   row_wraddr;
  logic         busy;
  mm_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mm_bram_tiled_acc_dpath dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_k_tiles (cfg_k_tiles),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .row_data_in (row_data_in),
    .weights     (weights),
    .row_addr_in (row_addr_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .row_data_out(row_data_out),
    .row_wraddr  (row_wraddr),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile(input logic [31:0] row, input logic [127:0] w,
                           input logic [2:0] k, input logic [4:0] addr);
    row_data_in = row;
    weights     = w;
    cfg_k_tiles = k;
    row_addr_in = addr;
    in_valid    = 1'b1;
    check("in_ready_beat", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      cycle();
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic take_out(input string tag, input logic [4:0] exp_addr, input int exp_lat);
    int n;
    logic [31:0] exp;
    exp = exp_q.pop_front();
    wait_valid(tag, n);
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_data"}, 64'(row_data_out), 64'(exp));
    check({tag, "_addr"}, 64'(row_wraddr), 64'(exp_addr));
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cfg_k_tiles = '0; row_data_in = '0; weights = '0; row_addr_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(row_data_out), 64'd0);
    check("rst_addr", 64'(row_wraddr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // Single tile: 1+2+3+4 = 10 per column.
    exp_q.push_back(32'h0A0A0A0A);
    send_tile(32'h04030201, {16{8'h01}}, 3'd1, 5'd7);
    take_out("single", 5'd7, 5);

    // Four tiles back-to-back: 2*3*16 = 96.
    exp_q.push_back(32'h60606060);
    for (int t = 0; t < 4; t++) send_tile(32'h02020202, {16{8'h03}}, 3'd4, 5'd3);
    check("four_drain_ready", 64'(in_ready), 64'd0);
    check("four_drain_busy", 64'(busy), 64'd1);
    take_out("four", 5'd3, 5);

    // Saturation high and low.
    exp_q.push_back(32'h7F7F7F7F);
    for (int t = 0; t < 4; t++) send_tile(32'h7F7F7F7F, {16{8'h7F}}, 3'd4, 5'd12);
    take_out("sat_hi", 5'd12, 5);
`ifdef MM_ACC_RELU_EN
    exp_q.push_back(32'h00000000);
`else
    exp_q.push_back(32'h80808080);
`endif
    for (int t = 0; t < 4; t++) send_tile(32'h7F7F7F7F, {16{8'h80}}, 3'd4, 5'd13);
    take_out("sat_lo", 5'd13, 5);

    // Gaps between tiles, cfg ignored after first, then 10 cycles of backpressure.
    exp_q.push_back(32'h26201A14);
    send_tile(32'h04030201, {4{32'h04030201}}, 3'd3, 5'd21);
    repeat (2) cycle();
    send_tile(32'hFFFFFFFF, {4{32'h03020100}}, 3'd1, 5'd0);
    cycle();
    send_tile(32'h05000000, {16{8'h02}}, 3'd1, 5'd0);
    wait_valid("gap_pre", n);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; row_data_in = 32'h11111111; cfg_k_tiles = 3'd1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      cycle();
    end
    in_valid = 1'b0;
    check("stall_addr", 64'(row_wraddr), 64'd21);
    take_out("gap", 5'd21, -1);
    for (int c = 0; c < 3; c++) begin
      check("post_single_xfer", 64'(out_valid), 64'd0);
      check("post_no_accept", 64'(busy), 64'd0);
      cycle();
    end

    // Reset after 2 of 4 tiles, then a clean one-tile row.
    send_tile(32'h01010101, {16{8'h01}}, 3'd4, 5'd5);
    send_tile(32'h01010101, {16{8'h01}}, 3'd4, 5'd5);
    reset = 1'b1;
    cycle();
    check("midrow_busy", 64'(busy), 64'd0);
    check("midrow_out_valid", 64'(out_valid), 64'd0);
    check("midrow_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    exp_q.push_back(32'h100C0804);
    send_tile(32'h01010101, {4{32'h04030201}}, 3'd1, 5'd2);
    take_out("after_rst", 5'd2, 5);

    // Reset while holding a result in OUT.
    send_tile(32'h01010101, {16{8'h01}}, 3'd1, 5'd9);
    wait_valid("midout_pre", n);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midout_valid", 64'(out_valid), 64'd0);
    check("midout_data", 64'(row_data_out), 64'd0);
    check("midout_addr", 64'(row_wraddr), 64'd0);
    check("midout_busy", 64'(busy), 64'd0);

    // cfg 0 behaves as one tile: -(1+2+3+4).
    exp_q.push_back(32'hF6F6F6F6);
    send_tile(32'h04030201, {16{8'hFF}}, 3'd0, 5'd30);
    take_out("cfg0", 5'd30, 5);

    // cfg 7 clamps to 4 tiles: 4*4 = 16.
    exp_q.push_back(32'h10101010);
    for (int t = 0; t < 4; t++) send_tile(32'h01010101, {16{8'h01}}, 3'd7, 5'd31);
    check("cfg7_clamped_ready", 64'(in_ready), 64'd0);
    take_out("cfg7", 5'd31, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
